// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, carry-chained ADC/SBC and bit-serial shifts (amt+1 cycles).
// ALU_SAT_EN enables signed saturating add/sub on ops 13/14; otherwise ops 13-15 are reserved.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             C_Out,
  output logic             Overflow,
  output logic             Negative,
  output logic             Zero,
  output logic             Illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state_q;
  logic             alive_q;
  logic             cf_q;
  logic [WIDTH-1:0] out_q;
  logic             c_q, ov_q, neg_q, zero_q, ill_q;
  logic [SHW-1:0]   cnt_q;
  logic [1:0]       shop_q;

  logic             accept;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_ov;
  logic [WIDTH-1:0] res;
  logic             res_c, res_ov, res_ill, go_shift;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_c;

  assign in_ready = alive_q && (state_q == IDLE || (state_q == HOLD && out_ready));
  assign accept   = in_valid && in_ready;
  assign amt      = B[SHW-1:0];

  // Subtractions share the adder as A + ~B + cin so C_Out reads as no-borrow.
  always_comb begin
    add_b   = B;
    add_cin = 1'b0;
    case (Op)
      4'd1, 4'd14: begin add_b = ~B; add_cin = 1'b1; end
      4'd2:        begin add_b = '0; add_cin = 1'b1; end
      4'd8:        add_cin = cf_q;
      4'd9:        begin add_b = ~B; add_cin = cf_q; end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_ov  = (A[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    res      = '0;
    res_c    = 1'b0;
    res_ov   = 1'b0;
    res_ill  = 1'b0;
    go_shift = 1'b0;
    case (Op)
      4'd0, 4'd1, 4'd2, 4'd8, 4'd9: begin
        res    = add_sum[WIDTH-1:0];
        res_c  = add_sum[WIDTH];
        res_ov = add_ov;
      end
      4'd3: res = A;
      4'd4: res = A & B;
      4'd5: res = A | B;
      4'd6: res = A ^ B;
      4'd7: res = ~A;
      4'd10, 4'd11, 4'd12: begin
        res      = A;
        go_shift = (amt != '0);
      end
`ifdef ALU_SAT_EN
      4'd13, 4'd14: begin
        res    = add_ov ? (A[WIDTH-1] ? SMIN : SMAX) : add_sum[WIDTH-1:0];
        res_ov = add_ov;
      end
`endif
      default: res_ill = 1'b1;
    endcase
  end

  // shop_q holds Op[1:0]: 2'b10 SHL, 2'b11 SHR, 2'b00 ASR.
  always_comb begin
    case (shop_q)
      2'b10:   begin sh_nxt = {out_q[WIDTH-2:0], 1'b0};         sh_c = out_q[WIDTH-1]; end
      2'b11:   begin sh_nxt = {1'b0, out_q[WIDTH-1:1]};         sh_c = out_q[0];       end
      default: begin sh_nxt = {out_q[WIDTH-1], out_q[WIDTH-1:1]}; sh_c = out_q[0];     end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      cf_q    <= 1'b0;
      out_q   <= '0;
      c_q     <= 1'b0;
      ov_q    <= 1'b0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      shop_q  <= 2'b00;
    end else begin
      alive_q <= 1'b1;
      case (state_q)
        SHIFT: begin
          out_q <= sh_nxt;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_q <= HOLD;
            c_q     <= sh_c;
            cf_q    <= sh_c;
            ov_q    <= 1'b0;
            neg_q   <= sh_nxt[WIDTH-1];
            zero_q  <= (sh_nxt == '0);
            ill_q   <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (go_shift) begin
              state_q <= SHIFT;
              out_q   <= A;
              cnt_q   <= amt;
              shop_q  <= Op[1:0];
            end else begin
              state_q <= HOLD;
              out_q   <= res;
              c_q     <= res_c;
              cf_q    <= res_c;
              ov_q    <= res_ov;
              neg_q   <= res[WIDTH-1];
              zero_q  <= (res == '0);
              ill_q   <= res_ill;
            end
          end else if (state_q == HOLD && out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = (state_q == HOLD);
  assign Out       = out_q;
  assign C_Out     = c_q;
  assign Overflow  = ov_q;
  assign Negative  = neg_q;
  assign Zero      = zero_q;
  assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed vector bench for alu_pipe (WIDTH=8); flags are packed {C_Out, Overflow, Negative, Zero, Illegal}.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [3:0] Op = 4'd0;
  logic       in_ready, out_valid;
  logic [7:0] Out;
  logic       C_Out, Overflow, Negative, Zero, Illegal;
  logic [4:0] flags;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic [4:0] fl;
  } vec_t;

  vec_t vecs[$];

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
    .Out(Out), .C_Out(C_Out), .Overflow(Overflow), .Negative(Negative),
    .Zero(Zero), .Illegal(Illegal)
  );

  assign flags = {C_Out, Overflow, Negative, Zero, Illegal};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] o, input logic [4:0] fl);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.o = o; v.fl = fl;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    chk("in_ready_at_issue", 32'(in_ready), 32'd1);
    Op = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic shift_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eo, input logic [4:0] efl, input int elat);
    int lat = 1;
    int ir_hi = 0;
    issue(op, a, b);
    while (!out_valid && lat < 40) begin
      if (in_ready) ir_hi++;
      @(negedge clk);
      lat++;
    end
    chk("shift_latency", 32'(lat), 32'(elat));
    chk("shift_in_ready_low", 32'(ir_hi), 32'd0);
    chk("shift_out", 32'(Out), 32'(eo));
    chk("shift_flags", 32'(flags), 32'(efl));
  endtask

  initial begin
    int wait_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(Out), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Issued back to back; the CF chain follows the order of the table.
    vecs.push_back(mk(4'd0,  8'h7F, 8'h01, 8'h80, 5'b01100));
    vecs.push_back(mk(4'd1,  8'h05, 8'h05, 8'h00, 5'b10010));
    vecs.push_back(mk(4'd9,  8'h00, 8'h00, 8'h00, 5'b10010));
    vecs.push_back(mk(4'd0,  8'hFF, 8'h01, 8'h00, 5'b10010));
    vecs.push_back(mk(4'd8,  8'h00, 8'h00, 8'h01, 5'b00000));
    vecs.push_back(mk(4'd2,  8'hFF, 8'h00, 8'h00, 5'b10010));
    vecs.push_back(mk(4'd4,  8'hF0, 8'h3C, 8'h30, 5'b00000));
    vecs.push_back(mk(4'd8,  8'h10, 8'h20, 8'h30, 5'b00000));
    vecs.push_back(mk(4'd5,  8'hF0, 8'h0F, 8'hFF, 5'b00100));
    vecs.push_back(mk(4'd6,  8'hF0, 8'h3C, 8'hCC, 5'b00100));
    vecs.push_back(mk(4'd7,  8'h55, 8'h00, 8'hAA, 5'b00100));
    vecs.push_back(mk(4'd3,  8'h00, 8'hFF, 8'h00, 5'b00010));
    vecs.push_back(mk(4'd1,  8'h80, 8'h01, 8'h7F, 5'b11000));
    vecs.push_back(mk(4'd9,  8'h00, 8'h01, 8'hFF, 5'b00100));
    vecs.push_back(mk(4'd9,  8'h00, 8'h00, 8'hFF, 5'b00100));
    vecs.push_back(mk(4'd0,  8'hFF, 8'h02, 8'h01, 5'b10000));
    vecs.push_back(mk(4'd15, 8'h12, 8'h34, 8'h00, 5'b00011));
    vecs.push_back(mk(4'd8,  8'h00, 8'h00, 8'h00, 5'b00010));
`ifdef ALU_SAT_EN
    vecs.push_back(mk(4'd13, 8'h70, 8'h20, 8'h7F, 5'b01000));
    vecs.push_back(mk(4'd14, 8'h80, 8'h01, 8'h80, 5'b01100));
    vecs.push_back(mk(4'd13, 8'hF0, 8'hF0, 8'hE0, 5'b00100));
`else
    vecs.push_back(mk(4'd13, 8'h70, 8'h20, 8'h00, 5'b00011));
    vecs.push_back(mk(4'd14, 8'h80, 8'h01, 8'h00, 5'b00011));
    vecs.push_back(mk(4'd13, 8'hF0, 8'hF0, 8'h00, 5'b00011));
`endif
    vecs.push_back(mk(4'd10, 8'h5A, 8'h08, 8'h5A, 5'b00000));
    vecs.push_back(mk(4'd12, 8'h80, 8'h00, 8'h80, 5'b00100));
    vecs.push_back(mk(4'd2,  8'h7F, 8'h00, 8'h80, 5'b01100));

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_out", i), 32'(Out), 32'(vecs[i].o));
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].fl));
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
    end

    // Multi-cycle shifts; latency counted in cycles from the accept edge.
    shift_op(4'd10, 8'h81, 8'h03, 8'h08, 5'b00000, 4);
    shift_op(4'd12, 8'h80, 8'h07, 8'hFF, 5'b00100, 8);
    shift_op(4'd11, 8'h03, 8'h01, 8'h01, 5'b10000, 2);
    issue(4'd8, 8'h00, 8'h00);
    chk("adc_after_shift_out", 32'(Out), 32'h01);
    shift_op(4'd11, 8'hB4, 8'h0A, 8'h2D, 5'b00000, 3);
    @(negedge clk);
    chk("valid_drops_after_transfer", 32'(out_valid), 32'd0);

    // Backpressure: result must stay put until out_ready returns.
    out_ready = 1'b0;
    issue(4'd6, 8'hF0, 8'h3C);
    chk("bp_first_out", 32'(Out), 32'hCC);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_out", 32'(Out), 32'hCC);
      chk("bp_hold_flags", 32'(flags), 32'b00100);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_after_transfer_valid", 32'(out_valid), 32'd0);

    // Reset in the third shift cycle of a long SHR, with CF=1 beforehand.
    issue(4'd0, 8'hFF, 8'h01);
    chk("pre_rst_carry", 32'(C_Out), 32'd1);
    issue(4'd11, 8'hFF, 8'h06);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(Out), 32'd0);
    chk("midrst_flags", 32'(flags), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("post_midrst_in_ready", 32'(in_ready), 32'd1);
    chk("post_midrst_out_valid", 32'(out_valid), 32'd0);
    issue(4'd8, 8'h01, 8'h01);
    chk("post_midrst_adc_out", 32'(Out), 32'h02);
    chk("post_midrst_adc_flags", 32'(flags), 32'b00000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Next-generation ALU: WIDTH-parametrised, registered, with valid/ready handshakes on input and output.
- Keeps the 8 base ops and flags of the combinational ALU.
- Adds carry-chained multi-word arithmetic (ADC/SBC) through a stored carry flag, plus multi-cycle iterative shifts.
- Sits between the datapath register file and the writeback stage.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4, power of 2).
- SHW, $clog2(WIDTH), shift-amount width; derived, not to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; for shifts, B[SHW-1:0] is the shift amount.
- Op  in  4  operation code.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- Out  out  WIDTH  result.
- C_Out, Overflow, Negative, Zero  out  1 each  flags of the result in Out.
- Illegal  out  1  result came from a reserved Op.

Behaviour:
- Reset values: in_ready=0 during reset and 1 after it; out_valid=0; Out=0; all flags=0; Illegal=0; stored carry CF=0; FSM=IDLE.
- FSM states:
  - IDLE: waiting.
  - SHIFT: iterating.
  - HOLD: result registered, waiting for out_ready.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This allows back-to-back issue, one op per cycle at full throughput.
- Single-cycle ops: accepted at edge t; Out/flags valid with out_valid=1 after edge t+1; state becomes HOLD.
- Ops (mod 2^WIDTH):
  - 0 ADD A+B.
  - 1 SUB A-B; C_Out = no-borrow.
  - 2 INC A+1.
  - 3 PASS A.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOT A.
  - 8 ADC A+B+CF.
  - 9 SBC A-B-(~CF), i.e. A+~B+CF.
  - 10 SHL.
  - 11 SHR (logical).
  - 12 ASR.
  - 13-15 reserved.
- Overflow is signed overflow for ops 0, 1, 2, 8, 9; 0 for all other ops.
- C_Out:
  - ops 0, 1, 2, 8, 9: carry-out of the WIDTH-bit add. SUB and SBC are computed as A+~B+cin.
  - shifts: the last bit shifted out.
  - all other ops: 0.
- Negative = Out[WIDTH-1]; Zero = (Out==0).
- CF is loaded with C_Out on every completed op, including logic ops, which clear it. CF is updated at the same edge Out is registered.
- Shifts: amt = B[SHW-1:0], captured at accept.
  - amt==0: behaves as a single-cycle op; Out=A, C_Out=0.
  - amt>0: go to SHIFT. One bit is shifted per cycle while an internal counter decrements. Transition to HOLD after the last shift.
  - out_valid rises after edge t+1+amt, where t is the accept edge; wait, i.e. first valid cycle is t+amt+1.
  - in_ready=0 throughout SHIFT.
  - ASR replicates the MSB.
- Reserved ops: Out=0, Zero=1, Illegal=1, C_Out=Ov=Neg=0, CF cleared. Single-cycle.
- HOLD with out_ready=0: Out, flags and Illegal are held stable, and in_ready=0.
- HOLD with out_ready=1 and no new accept: returns to IDLE, out_valid=0.
- HOLD with out_ready=1 and a simultaneous accept: the new op replaces the result. ADC/SBC accepted there use the CF just produced by the completing op.
- Reset asserted mid-operation (any state): the operation is aborted immediately, with no partial result; all outputs return to their reset values.
- Input signals other than in_valid are don't-care when in_valid=0.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined:
  - Op 13 = SADD and Op 14 = SSUB: signed saturating add/sub, clamped to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - Overflow=1 when clamping occurred; C_Out=0; CF cleared.
  - Op 15 stays reserved.
- Not defined: Ops 13-15 are all reserved and give the Illegal response.

Test Plan:
- WIDTH=8, ADD A=0x7F B=0x01, out_ready=1 -> next cycle Out=0x80, Ov=1, Neg=1, C_Out=0, Zero=0, out_valid high exactly 1 cycle.
- SUB A=0x05 B=0x05 -> Out=0x00, Zero=1, C_Out=1, Ov=0. Then SBC A=0x00 B=0x00 -> Out=0x00, C_Out=1.
- Multi-word: ADD 0xFF+0x01 -> Out=0x00, C_Out=1. Back-to-back ADC 0x00+0x00 -> Out=0x01, C_Out=0, with no idle cycle between accepts.
- SHL A=0x81 B=3 accepted at cycle t -> in_ready=0 for cycles t+1..t+3; out_valid first seen at cycle t+4; Out=0x08, C_Out=0. Also ASR A=0x80 B=7 -> Out=0xFF, Neg=1.
- Backpressure: complete XOR 0xF0^0x3C with out_ready=0 for 5 cycles -> Out=0xCC held stable, in_ready=0. Then out_ready=1 -> one transfer, in_ready=1.
- Reset during SHR A=0xFF B=6 at the 3rd shift cycle -> out_valid=0, Out=0, CF=0. After release, ADC 0x01+0x01 -> Out=0x02.
- With ALU_SAT_EN: SADD 0x70+0x20 -> Out=0x7F, Ov=1.
- Without ALU_SAT_EN: Op 13 -> Illegal=1, Zero=1.
